// File: rtl/alu_seq.sv
// Registered, handshaked ALU: logic, add/sub, shifts in one cycle and an
// iterative shift-add multiply, with Z/C/V/N flags and illegal-opcode error.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [SHW:0]   CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0]   CNT_LAST = (SHW+1)'(WIDTH);
  localparam logic [3:0]     OP_MUL   = 4'd9;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [SHW:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d, err_q, err_d;
  logic                   out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic [SHW-1:0]         sh_s;
  logic [WIDTH:0]         ext_s;
  logic [WIDTH-1:0]       alu_res_s;
  logic                   alu_c_s, alu_v_s, alu_err_s;

  // Single-cycle datapath, evaluated on the live operands at accept time.
  always_comb begin
    sh_s      = b[SHW-1:0];
    ext_s     = '0;
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      4'd0: alu_res_s = a & b;
      4'd1: alu_res_s = a | b;
      4'd2: alu_res_s = a ^ b;
      4'd3: alu_res_s = ~a;
      4'd4: begin
        ext_s     = {1'b0, a} + {1'b0, b};
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (ext_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'd5: begin
        ext_s     = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (ext_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'd6: begin
        ext_s     = {1'b0, a} << sh_s;
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
      end
      4'd7: begin
        ext_s     = {a, 1'b0} >> sh_s;
        alu_res_s = ext_s[WIDTH:1];
        alu_c_s   = ext_s[0];
      end
      4'd8: begin
        ext_s     = $unsigned($signed({a, 1'b0}) >>> sh_s);
        alu_res_s = ext_s[WIDTH:1];
        alu_c_s   = ext_s[0];
      end
      4'd9:    alu_res_s = '0;
      default: alu_err_s = 1'b1;
    endcase
  end

  // Next-state and output-register logic for IDLE/BUSY/HOLD.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    n_d         = n_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && (op == OP_MUL)) begin
          state_d    = S_BUSY;
          mcand_d    = {{WIDTH{1'b0}}, a};
          mplier_d   = b;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end else if (in_valid) begin
          state_d     = S_HOLD;
          result_d    = alu_res_s;
          c_d         = alu_c_s;
          v_d         = alu_v_s;
          z_d         = !alu_err_s && (alu_res_s == '0);
          n_d         = alu_res_s[WIDTH-1];
          err_d       = alu_err_s;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      // WIDTH shift-add steps, then one edge to publish the product and flags.
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = S_HOLD;
          result_d    = acc_q[WIDTH-1:0];
          c_d         = |acc_q[2*WIDTH-1:WIDTH];
          v_d         = |acc_q[2*WIDTH-1:WIDTH];
          z_d         = (acc_q[WIDTH-1:0] == '0);
          n_d         = acc_q[WIDTH-1];
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      n_q         <= n_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;
  assign out_err   = err_q;

endmodule
